fifo_param: RTL and testbench

Parametrised synchronous FIFO; next generation of the team's fixed 16-bit simple FIFO. Adds:
- configurable width and depth
- occupancy count
- programmable almost-full / almost-empty flags
- sticky overflow/underflow error flags
- defined simultaneous read/write at the full and empty boundaries
Sits between producer and consumer blocks in one clock domain.

---
 rtl/fifo_param.sv | 99 +++++++++
 tb/tb_fifo_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags and sticky errors.
// Optional build macro FIFO_FWFT_EN selects first-word fall-through output instead of registered dout.
module fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  write,
    input  logic                  read,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = (ADDR_WIDTH)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // A read on a full FIFO frees the slot the simultaneous write needs.
    assign rd_acc = read & ~empty;
    assign wr_acc = write & (~full | rd_acc);

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A new error in the same cycle as err_clr keeps the flag set.
            if (write && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (read && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign dout = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (rd_acc) begin
            dout <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: queue-based reference model compared every cycle,
// directed boundary scenarios with literal expectations, then randomized traffic.
module tb_fifo_param;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          write;
    logic          read;
    logic          err_clr;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int tests_run    = 0;
    int tests_failed = 0;
    bit checking     = 1'b0;

    fifo_param #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .write       (write),
        .read        (read),
        .err_clr     (err_clr),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, registered output and sticky flags as plain variables.
    logic [DW-1:0] q[$];
    int            m_dout = 0;
    bit            m_ovf  = 1'b0;
    bit            m_und  = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_dout = 0;
            m_ovf  = 1'b0;
            m_und  = 1'b0;
        end else begin
            bit rd_ok;
            bit wr_ok;
            rd_ok = read && (q.size() > 0);
            wr_ok = write && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_dout = int'(q.pop_front());
            if (wr_ok) q.push_back(din);
            if (write && !wr_ok) m_ovf = 1'b1;
            else if (err_clr) m_ovf = 1'b0;
            if (read && !rd_ok) m_und = 1'b1;
            else if (err_clr) m_und = 1'b0;
        end
    end

    function automatic int expected_dout();
`ifdef FIFO_FWFT_EN
        return (q.size() > 0) ? int'(q[0]) : 0;
`else
        return m_dout;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking && reset) begin
            int n;
            n = q.size();
            checkOutput("cyc_count",        int'(count),        n);
            checkOutput("cyc_empty",        int'(empty),        int'(n == 0));
            checkOutput("cyc_full",         int'(full),         int'(n == DEPTH));
            checkOutput("cyc_almost_full",  int'(almost_full),  int'(n >= AF));
            checkOutput("cyc_almost_empty", int'(almost_empty), int'(n <= AE));
            checkOutput("cyc_overflow",     int'(overflow),     int'(m_ovf));
            checkOutput("cyc_underflow",    int'(underflow),    int'(m_und));
            checkOutput("cyc_dout",         int'(dout),         expected_dout());
        end
    end

    // Drive one cycle of inputs and return just after the edge that consumes them.
    task automatic applyStimulus(input bit w, input bit r, input int d, input bit clr);
        write   = w;
        read    = r;
        din     = DW'(d);
        err_clr = clr;
        @(posedge clk);
        #2;
        write   = 1'b0;
        read    = 1'b0;
        err_clr = 1'b0;
    endtask

    // Pop one entry and pin its value: before the pop in fall-through mode, after it otherwise.
    task automatic readExpect(input string name, input int val);
`ifdef FIFO_FWFT_EN
        checkOutput(name, int'(dout), val);
        applyStimulus(1'b0, 1'b1, 0, 1'b0);
`else
        applyStimulus(1'b0, 1'b1, 0, 1'b0);
        checkOutput(name, int'(dout), val);
`endif
    endtask

    initial begin
        int vals1[4] = '{100, 10, 250, 40};
        int wprob[6] = '{80, 20, 60, 95, 5, 50};

        reset   = 1'b0;
        din     = '0;
        write   = 1'b0;
        read    = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset    = 1'b1;
        checking = 1'b1;

        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_empty", int'(empty), 1);
        checkOutput("rst_full", int'(full), 0);
        checkOutput("rst_almost_empty", int'(almost_empty), 1);
        checkOutput("rst_almost_full", int'(almost_full), 0);
        checkOutput("rst_dout", int'(dout), 0);

        // Basic ordering
        foreach (vals1[i]) applyStimulus(1'b1, 1'b0, vals1[i], 1'b0);
        checkOutput("t1_count4", int'(count), 4);
        foreach (vals1[i]) readExpect("t1_dout", vals1[i]);
        checkOutput("t1_count0", int'(count), 0);
        checkOutput("t1_empty", int'(empty), 1);
        checkOutput("t1_flags", int'({overflow, underflow}), 0);

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, i, 1'b0);
            if (i == 12) checkOutput("t2_af_below", int'(almost_full), 0);
            if (i == 13) checkOutput("t2_af_at14", int'(almost_full), 1);
        end
        checkOutput("t2_full", int'(full), 1);
        checkOutput("t2_count16", int'(count), 16);
        applyStimulus(1'b1, 1'b0, 77, 1'b0);
        checkOutput("t2_overflow", int'(overflow), 1);
        checkOutput("t2_count_hold", int'(count), 16);

        // Simultaneous read/write at full
`ifdef FIFO_FWFT_EN
        checkOutput("t3_head", int'(dout), 0);
        applyStimulus(1'b1, 1'b1, 99, 1'b0);
`else
        applyStimulus(1'b1, 1'b1, 99, 1'b0);
        checkOutput("t3_dout", int'(dout), 0);
`endif
        checkOutput("t3_count", int'(count), 16);
        checkOutput("t3_full", int'(full), 1);
        for (int i = 1; i < 16; i++) readExpect("t3_wrap", i);
        readExpect("t3_last", 99);
        checkOutput("t3_empty", int'(empty), 1);

        // Simultaneous read/write at empty, error clearing
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("t4_ovf_clr", int'(overflow), 0);
        applyStimulus(1'b1, 1'b1, 7, 1'b0);
        checkOutput("t4_count1", int'(count), 1);
        checkOutput("t4_underflow", int'(underflow), 1);
`ifdef FIFO_FWFT_EN
        checkOutput("t4_dout_head", int'(dout), 7);
`else
        checkOutput("t4_dout_hold", int'(dout), 99);
`endif
        readExpect("t4_dout7", 7);
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        checkOutput("t4_set_wins", int'(underflow), 1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("t4_und_clr", int'(underflow), 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 200 + i, 1'b0);
        #1 reset = 1'b0;
        #1;
        checkOutput("t5_count", int'(count), 0);
        checkOutput("t5_empty", int'(empty), 1);
        checkOutput("t5_dout", int'(dout), 0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 55, 1'b0);
        readExpect("t5_dout55", 55);

`ifdef FIFO_FWFT_EN
        applyStimulus(1'b1, 1'b0, 42, 1'b0);
        checkOutput("t6_fall_through", int'(dout), 42);
        applyStimulus(1'b0, 1'b1, 0, 1'b0);
        checkOutput("t6_dout0", int'(dout), 0);
        checkOutput("t6_empty", int'(empty), 1);
`endif

        // Randomized traffic with phases biased toward full and toward empty
        foreach (wprob[p]) begin
            for (int c = 0; c < 300; c++) begin
                bit w;
                bit r;
                w = ($urandom_range(0, 99) < wprob[p]);
                r = ($urandom_range(0, 99) < (100 - wprob[p]));
                applyStimulus(w, r, int'($urandom_range(0, 65535)), ($urandom_range(0, 99) < 5));
            end
        end

        @(negedge clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
